// File: rtl/bubble_out_sequencer.sv
// bubble_out_sequencer
// Paces one bubble-memory output access (BOOT or USER) as a sequence of
// bubble output cycles derived from MCLK.
//
// Each access runs IDLE -> PREP -> RUN -> FINISH -> IDLE.
// - PREP is the settling delay: START_DLY whole bubble cycles with no ticks.
// - RUN emits BOUTTICKS[0] at phase 0 and BOUTTICKS[1] at phase TICK1_OFS
//   of every bubble cycle.
// - BOUTCYCLENUM advances only on the phase wrap, so it is stable whenever
//   the read strobe fires.
//
// Optional build macro: BOUT_SEQ_ABORT_EN
// - Defined: adds the active-low nABORT input. nABORT low in PREP or RUN
//   ends the access early through FINISH.
// - Undefined: the port does not exist and every access runs to its last
//   cycle.
//
// Every output comes straight from a flop. Next-state values are computed
// combinationally and registered together, so the outputs never depend
// combinationally on the inputs.
module bubble_out_sequencer #(
    parameter int CYCLE_DIV = 480,
    parameter int TICK1_OFS = 2,
    parameter int BOOT_LAST = 7751,
    parameter int USER_LAST = 1023,
    parameter int START_DLY = 16
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic [2:0]  REQTYPE,
`ifdef BOUT_SEQ_ABORT_EN
    input  logic        nABORT,
`endif
    output logic [2:0]  ACCTYPE,
    output logic [12:0] BOUTCYCLENUM,
    output logic [1:0]  BOUTTICKS,
    output logic        BUSY,
    output logic        DONE,
    output logic        REJECT
);

    // Phase counter is wide enough for 0..CYCLE_DIV-1.
    localparam int PH_W = $clog2(CYCLE_DIV);

    // Counter of completed bubble cycles while in PREP.
    localparam int DLY_W = (START_DLY > 2) ? $clog2(START_DLY) : 1;

    // A zero settling delay skips PREP entirely.
    localparam bit ZERO_DLY = (START_DLY == 0);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYCLE_DIV - 1);
    localparam logic [PH_W-1:0]  PH_TICK1 = PH_W'(TICK1_OFS);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DLY - 1);

    localparam logic [12:0] BOOT_LAST_V = 13'(BOOT_LAST);
    localparam logic [12:0] USER_LAST_V = 13'(USER_LAST);
    localparam logic [12:0] CNUM_IDLE   = 13'h1FFF;

    localparam logic [2:0] TYPE_NONE = 3'b000;
    localparam logic [2:0] TYPE_BOOT = 3'b110;
    localparam logic [2:0] TYPE_USER = 3'b111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PREP   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [PH_W-1:0]  phase_q,   phase_d;
    logic [DLY_W-1:0] dly_q,     dly_d;
    logic [2:0]       acctype_q, acctype_d;
    logic [12:0]      cnum_q,    cnum_d;
    logic [1:0]       ticks_q,   ticks_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             reject_q,  reject_d;

    logic             abort_req;
    logic             type_ok;
    logic             phase_wrap;
    logic             go_finish;
    logic [12:0]      last_cnum;

`ifdef BOUT_SEQ_ABORT_EN
    assign abort_req = ~nABORT;
`else
    assign abort_req = 1'b0;
`endif

    assign type_ok    = (REQTYPE == TYPE_BOOT) || (REQTYPE == TYPE_USER);
    assign phase_wrap = (phase_q == PH_LAST);
    assign last_cnum  = (acctype_q == TYPE_BOOT) ? BOOT_LAST_V : USER_LAST_V;

    // Sequencer next state: access acceptance, PREP delay, cycle counting and finish.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dly_d     = dly_q;
        acctype_d = acctype_q;
        cnum_d    = cnum_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        go_finish = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                dly_d   = '0;
                if (START) begin
                    if (type_ok) begin
                        acctype_d = REQTYPE;
                        if (ZERO_DLY) begin
                            state_d = ST_RUN;
                            cnum_d  = '0;
                        end else begin
                            state_d = ST_PREP;
                        end
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            ST_PREP: begin
                // A START while busy is refused and disturbs nothing else.
                reject_d = START;
                if (abort_req) begin
                    go_finish = 1'b1;
                end else if (phase_wrap) begin
                    phase_d = '0;
                    if (dly_q == DLY_LAST) begin
                        state_d = ST_RUN;
                        cnum_d  = '0;
                        dly_d   = '0;
                    end else begin
                        dly_d = dly_q + DLY_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_RUN: begin
                reject_d = START;
                if (abort_req) begin
                    go_finish = 1'b1;
                end else if (phase_wrap) begin
                    phase_d = '0;
                    // The last cycle number is held, never incremented past.
                    if (cnum_q == last_cnum) begin
                        go_finish = 1'b1;
                    end else begin
                        cnum_d = cnum_q + 13'd1;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_FINISH: begin
                reject_d = START;
                state_d  = ST_IDLE;
                phase_d  = '0;
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        // FINISH already presents the idle values alongside the DONE pulse.
        if (go_finish) begin
            state_d   = ST_FINISH;
            phase_d   = '0;
            dly_d     = '0;
            acctype_d = TYPE_NONE;
            cnum_d    = CNUM_IDLE;
            done_d    = 1'b1;
        end
    end

    // Tick and busy flags are derived from the next state so they line up with it.
    always_comb begin
        ticks_d    = 2'b00;
        ticks_d[0] = (state_d == ST_RUN) && (phase_d == '0);
        ticks_d[1] = (state_d == ST_RUN) && (phase_d == PH_TICK1);
        busy_d     = (state_d == ST_PREP) || (state_d == ST_RUN);
    end

    // State and output registers; reset forces the idle picture immediately.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            dly_q     <= '0;
            acctype_q <= TYPE_NONE;
            cnum_q    <= CNUM_IDLE;
            ticks_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dly_q     <= dly_d;
            acctype_q <= acctype_d;
            cnum_q    <= cnum_d;
            ticks_q   <= ticks_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
        end
    end

    assign ACCTYPE      = acctype_q;
    assign BOUTCYCLENUM = cnum_q;
    assign BOUTTICKS    = ticks_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign REJECT       = reject_q;

endmodule
